// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Holds the FSM state encoding used by serial_subtractor.
package sub_pkg;

    localparam int DEFAULT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with bout as the borrow out.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor D = A - B, LSB first, one bit per clock,
// with a start/busy/done handshake and held result.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] D,
    output logic         Bout
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    logic [W-1:0]  sa;
    logic [W-1:0]  sb;
    logic [W-1:0]  acc;
    logic          borrow;
    logic [CW-1:0] cnt;
    logic          bit_d;
    logic          bit_bout;

    full_subtractor_cell u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (borrow),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            D      <= '0;
            Bout   <= 1'b0;
            sa     <= '0;
            sb     <= '0;
            acc    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa     <= A;
                        sb     <= B;
                        acc    <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    acc    <= {bit_d, acc[W-1:1]};
                    borrow <= bit_bout;
                    cnt    <= cnt + 1'b1;
                    // Final bit: publish the result straight from the cell output.
                    if (cnt == LAST) begin
                        D     <= {bit_d, acc[W-1:1]};
                        Bout  <= bit_bout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed scoreboard bench for serial_subtractor (W = 4).
module tb_serial_subtractor;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bout;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    serial_subtractor #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int a, input int b);
        exp_t e;
        e.d = W'(a - b);
        e.b = (a < b);
        sb_q.push_back(e);
    endtask

    // Drive start for one accepting edge; returns at the negedge after acceptance.
    task automatic launch(input int a, input int b);
        @(negedge clk);
        start = 1'b1;
        A     = W'(a);
        B     = W'(b);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done, sampling on negedges; pops and compares the result.
    task automatic wait_done(input string tag, input int exp_cycles);
        int   cycles;
        int   busy_cnt;
        exp_t e;
        cycles   = 0;
        busy_cnt = 0;
        while (cycles < 20) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) break;
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        if (exp_cycles > 0) begin
            check({tag, "_latency"}, 32'(cycles), 32'(exp_cycles));
            check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_cycles));
        end
        check({tag, "_queue"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_D"}, 32'(D), 32'(e.d));
            check({tag, "_Bout"}, 32'(Bout), 32'(e.b));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;

        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_D", 32'(D), 32'd0);
        check("reset_Bout", 32'(Bout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Equal operands, then underflow and normal cases.
        launch(15, 15); push_exp(15, 15); wait_done("eq15", W);
        @(negedge clk);
        check("eq15_done_pulse", 32'(done), 32'd0);
        launch(0, 1);   push_exp(0, 1);   wait_done("u0_1", W);
        launch(3, 9);   push_exp(3, 9);   wait_done("u3_9", W);
        launch(9, 3);   push_exp(9, 3);   wait_done("n9_3", W);
        launch(8, 0);   push_exp(8, 0);   wait_done("n8_0", W);

        // Start while busy is ignored; operands changed mid-flight too.
        launch(12, 5); push_exp(12, 5);
        @(negedge clk);
        start = 1'b1;
        A     = 4'd1;
        B     = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", W - 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("ign_no_done", 32'(done), 32'd0);
            check("ign_hold_D", 32'(D), 32'd7);
        end
        check("ign_hold_Bout", 32'(Bout), 32'd0);

        // Asynchronous reset mid-operation.
        launch(5, 14);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_D", 32'(D), 32'd0);
        check("mid_rst_Bout", 32'(Bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(6, 6); push_exp(6, 6); wait_done("post_rst", W);

        // Back-to-back: start held in the DONE cycle.
        launch(9, 3); push_exp(9, 3);
        wait_done("b2b_first", W);
        start = 1'b1;
        A     = 4'd2;
        B     = 4'd7;
        push_exp(2, 7);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_no_gap", 32'(busy), 32'd1);
        check("b2b_prior_D", 32'(D), 32'd6);
        wait_done("b2b_second", W);
        @(negedge clk);
        check("b2b_done_pulse", 32'(done), 32'd0);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial W-bit subtractor computing D = A - B with a borrow-out. It is the subtract-direction companion to the combinational ripple-carry adder, and processes one bit per clock, LSB first, through a single full-subtractor cell. A start/busy/done handshake lets a controller or testbench launch one operation at a time and collect a held result.

Parameters:
- W, 4, operand and result width in bits (W >= 2).
- CW, $clog2(W+1), bit-counter width; derived, not overridden.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, launch request; sampled only in IDLE or DONE.
- A, input, W, minuend; sampled on the edge that accepts start.
- B, input, W, subtrahend; sampled on the edge that accepts start.
- busy, output, 1, high while an operation is in progress (state RUN).
- done, output, 1, one-cycle pulse marking the result update.
- D, output, W, difference (A - B) mod 2^W; held between operations.
- Bout, output, 1, final borrow; 1 iff A < B unsigned; held with D.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state = IDLE.
  - busy = 0, done = 0, D = 0, Bout = 0.
  - Shift registers, internal borrow and bit counter are cleared.
- FSM states: IDLE, RUN, DONE. busy is registered and equals (state == RUN). done is registered and equals (state == DONE).
- IDLE:
  - start = 1 at edge E0: latch A into sa, B into sb, borrow = 0, cnt = 0, go to RUN.
  - start = 0: stay in IDLE.
- RUN, each edge:
  - a = sa[0], b = sb[0].
  - d = a ^ b ^ borrow.
  - borrow_next = (~a & b) | (~(a ^ b) & borrow).
  - sa, sb shift right by one. d shifts into the MSB of accumulator acc. cnt increments.
  - When cnt == W-1 at the edge: load D = {d, acc[W-1:1]} and Bout = borrow_next, then go to DONE.
- Latency:
  - Start accepted at E0; bits are processed at edges E1..EW.
  - busy = 1 from after E0 until after EW.
  - done = 1 for exactly the one cycle after EW.
  - D and Bout change only at EW and are stable from then until the next completion.
- DONE (one cycle only):
  - start = 1: accepted exactly as in IDLE (back-to-back operation), go to RUN. done still pulses this cycle.
  - start = 0: go to IDLE.
- start while busy: ignored. The operands are not re-sampled and the operation finishes unchanged.
- A and B may change freely while busy; they have no effect on the operation in flight.
- Reset mid-operation: the result is discarded and all outputs return to 0 immediately. No done pulse is produced.
- Arithmetic: unsigned W-bit. Signed overflow is not flagged. D equals the W-bit two's-complement wrap of A - B.

Decomposition:
- Shared package sub_pkg:
  - State enum { IDLE, RUN, DONE }, 2 bits.
  - Localparam DEFAULT_W = 4.
- Sub-module full_subtractor_cell:
  - Purely combinational.
  - Inputs a, b, bin; outputs d, bout.
  - Instantiated once inside serial_subtractor.

Test Plan:
- Basic equal operands: after reset, start with A=15, B=15 -> done pulses 4 cycles after acceptance; D=0, Bout=0; busy high for exactly 4 cycles.
- Underflow: A=0, B=1 -> D=15, Bout=1. A=3, B=9 -> D=10, Bout=1.
- Normal subtraction: A=9, B=3 -> D=6, Bout=0. A=8, B=0 -> D=8, Bout=0.
- Ignored start: launch A=12, B=5, then pulse start with A=1, B=2 at busy cycle 2 -> only one done; D=7, Bout=0. D holds 7 for 10 further idle cycles.
- Reset mid-operation: assert rst_n=0 asynchronously mid-cycle during RUN -> busy, done, D, Bout read 0 immediately. After release, A=6, B=6 gives D=0, Bout=0 with normal latency.
- Back-to-back: hold start=1 in the DONE cycle with A=2, B=7 -> busy rises the next cycle with no IDLE gap; second done shows D=11, Bout=1. First result (prior op) visible during RUN.
